// File: rtl/rx_fifo_burst_tracker.sv
// rtl/rx_fifo_burst_tracker.sv - RX ring FIFO writer and burst reservation tracker
//
// Purpose:
//   Writes the front-end word stream into the RX ring FIFO RAM and cuts it into
//   fixed-size bursts. Ring space is reserved one burst at a time on the first
//   word of each burst. A burst that finds the ring full is dropped as a whole.
//   The DMA engine returns space with fifo_burst_release pulses.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dma_en              low = synchronous clear of all state
//   cfg_brst_words_z    words per burst minus 1
//   cfg_ring_bursts_z   bursts the ring holds minus 1
//   cfg_max_payload_sz  PCIe MPS code (0=128B .. 3=1024B), sets the mlowmrk step
//   s_word_valid/data   front-end word stream, no backpressure
//   fifo_we/waddr/wdata ring RAM write port, registered
//   fifo_burst_fill     pulse with the write of a burst's last word
//   fifo_burst_skip     pulse one cycle after the last word of a dropped burst
//   fifo_burst_mlowmrk  pulse with the write that completes an MPS chunk
//   fifo_burst_avail_z  free bursts minus 1; all-ones = none free
//   fifo_burst_release  pulse from DMA: one burst freed
//   release_err         sticky: release seen with nothing reserved
//   ovf_bursts          saturating count of dropped bursts
//
// Optional feature macro: RX_OVF_STATS_EN builds the ovf_bursts counter;
// without it ovf_bursts is tied to zero.

module rx_fifo_burst_tracker #(
  parameter int BUFFER_SIZE_BITS = 16,
  parameter int DATA_BITS        = 4,
  parameter int DATA_WIDTH       = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dma_en,
  input  logic [BUFFER_SIZE_BITS-DATA_BITS-1:0] cfg_brst_words_z,
  input  logic [BUFFER_SIZE_BITS-6:0]       cfg_ring_bursts_z,
  input  logic [1:0]                        cfg_max_payload_sz,
  input  logic                              s_word_valid,
  input  logic [DATA_WIDTH-1:0]             s_word_data,
  output logic                              fifo_we,
  output logic [BUFFER_SIZE_BITS-DATA_BITS-1:0] fifo_waddr,
  output logic [DATA_WIDTH-1:0]             fifo_wdata,
  output logic                              fifo_burst_fill,
  output logic                              fifo_burst_skip,
  output logic                              fifo_burst_mlowmrk,
  output logic [BUFFER_SIZE_BITS-6:0]       fifo_burst_avail_z,
  input  logic                              fifo_burst_release,
  output logic                              release_err,
  output logic [15:0]                       ovf_bursts
);

  localparam int AW  = BUFFER_SIZE_BITS - DATA_BITS;
  localparam int RBW = BUFFER_SIZE_BITS - 5;
  localparam int RSW = BUFFER_SIZE_BITS - 4;

  typedef enum logic [1:0] {IDLE, FILL, SKIP} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  cnt, cnt_nx;
  logic [AW-1:0]  wptr;
  logic [RSW-1:0] resv;
  logic [RBW-1:0] resv_q;

  logic           fits, take, drop, last, reserve, mlow_hit;
  logic [AW:0]    word_n;
  logic [31:0]    thr_words, thr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!dma_en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    fits      = (resv <= {1'b0, cfg_ring_bursts_z});
    take      = s_word_valid && ((state == FILL) || ((state == IDLE) && fits));
    drop      = s_word_valid && ((state == SKIP) || ((state == IDLE) && !fits));
    reserve   = s_word_valid && (state == IDLE) && fits;
    last      = (cnt == cfg_brst_words_z);
    // 1-based index of the current word inside its burst
    word_n    = {1'b0, cnt} + 1'b1;
    thr_words = (32'd128 << cfg_max_payload_sz) >> DATA_BITS;
    thr_mask  = thr_words - 32'd1;
    // Thresholds are powers of two, so "n mod T == 0" is a mask test
    mlow_hit  = take && !last && (thr_words != 32'd0) &&
                ((32'(word_n) & thr_mask) == 32'd0);
    if (s_word_valid) begin
      cnt_nx   = last ? '0 : cnt + 1'b1;
      state_nx = last ? IDLE : (take ? FILL : SKIP);
    end
  end

  // Write port and burst pulses. fifo_waddr follows the write pointer while
  // idle and shows the address of the word being written when fifo_we is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr               <= '0;
      fifo_we            <= 1'b0;
      fifo_waddr         <= '0;
      fifo_wdata         <= '0;
      fifo_burst_fill    <= 1'b0;
      fifo_burst_skip    <= 1'b0;
      fifo_burst_mlowmrk <= 1'b0;
    end else if (!dma_en) begin
      wptr               <= '0;
      fifo_we            <= 1'b0;
      fifo_waddr         <= '0;
      fifo_wdata         <= '0;
      fifo_burst_fill    <= 1'b0;
      fifo_burst_skip    <= 1'b0;
      fifo_burst_mlowmrk <= 1'b0;
    end else begin
      fifo_we            <= take;
      fifo_waddr         <= wptr;
      fifo_burst_fill    <= take && last;
      fifo_burst_skip    <= drop && last;
      fifo_burst_mlowmrk <= mlow_hit;
      if (take) begin
        fifo_wdata <= s_word_data;
        wptr       <= wptr + 1'b1;
      end
    end
  end

  // Reservation counter. A release that lands on the same cycle as a
  // reservation cancels it, so an empty counter is never decremented there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv        <= '0;
      resv_q      <= '0;
      release_err <= 1'b0;
    end else if (!dma_en) begin
      resv        <= '0;
      resv_q      <= '0;
      release_err <= 1'b0;
    end else begin
      resv_q <= resv[RBW-1:0];
      case ({reserve, fifo_burst_release})
        2'b10: resv <= resv + 1'b1;
        2'b01: begin
          if (resv == '0) release_err <= 1'b1;
          else            resv        <= resv - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // resv_q lags resv by one cycle; config is static while enabled, so the
  // difference behaves as a registered value and equals the config at reset.
  assign fifo_burst_avail_z = cfg_ring_bursts_z - resv_q;

`ifdef RX_OVF_STATS_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (!dma_en) begin
      ovf_cnt <= '0;
    end else if (drop && last && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign ovf_bursts = ovf_cnt;
`else
  assign ovf_bursts = 16'd0;
`endif

endmodule
